instrs_buff: RTL and testbench

Circular instruction buffer between the fetch stage and decode. Fetch pushes {pc, instr} pairs through a valid/ready handshake. Decode pops them in order through a second valid/ready handshake. A backend redirect (`flush`) empties the buffer in one cycle. Registered head/tail/reload values are exported so that the DPI-C performance probe downstream can sample buffer occupancy and reload events each cycle.

---
 rtl/instrs_buff.sv | 94 +++++++++
 tb/tb_instrs_buff.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instrs_buff.sv
// instrs_buff: circular instruction buffer between fetch and decode.
// Fetch pushes {pc, instr} pairs and decode pops them in order.
// A flush empties the buffer in one cycle. Registered head/tail/reload
// values are exported for a downstream performance probe.
module instrs_buff #(
  parameter int DEPTH       = 8,
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  input  logic                   flush,
  output logic [7:0]             perf_head,
  output logic [7:0]             perf_tail,
  output logic [7:0]             perf_reload
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [PC_WIDTH-1:0]    mem_pc    [DEPTH];
  logic [INSTR_WIDTH-1:0] mem_instr [DEPTH];

  logic [AW:0] head;
  logic [AW:0] tail;
  logic [AW:0] head_nxt;
  logic [AW:0] tail_nxt;
  logic        full;
  logic        empty;
  logic        do_enq;
  logic        do_deq;

  // The MSB of each pointer is a wrap bit: equal pointers mean empty,
  // equal indices with differing wrap bits mean full.
  assign empty = (head == tail);
  assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);

  // Handshake status comes only from registered pointers, so there is no
  // combinational path from in_valid/out_ready back to in_ready/out_valid.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_pc    = mem_pc[head[AW-1:0]];
  assign out_instr = mem_instr[head[AW-1:0]];

  assign do_enq = in_valid && !full && !flush;
  assign do_deq = !empty && out_ready && !flush;

  // Next pointer values; flush discards everything and beats both handshakes.
  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    if (flush) begin
      head_nxt = '0;
      tail_nxt = '0;
    end else begin
      if (do_enq) tail_nxt = tail + PTR_ONE;
      if (do_deq) head_nxt = head + PTR_ONE;
    end
  end

  // Pointers and perf registers; perf values come from the same next-state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      perf_head   <= 8'd0;
      perf_tail   <= 8'd0;
      perf_reload <= 8'd0;
    end else begin
      head        <= head_nxt;
      tail        <= tail_nxt;
      perf_head   <= {{(8-AW){1'b0}}, head_nxt[AW-1:0]};
      perf_tail   <= {{(8-AW){1'b0}}, tail_nxt[AW-1:0]};
      perf_reload <= {7'd0, flush};
    end
  end

  // Storage write at the tail index; contents are never cleared.
  always_ff @(posedge clk) begin
    if (!rst && do_enq) begin
      mem_pc[tail[AW-1:0]]    <= in_pc;
      mem_instr[tail[AW-1:0]] <= in_instr;
    end
  end

endmodule

// File: tb/tb_instrs_buff.sv
// tb_instrs_buff: scoreboard bench for instrs_buff at DEPTH=4.
module tb_instrs_buff;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        flush;
  logic [7:0]  perf_head;
  logic [7:0]  perf_tail;
  logic [7:0]  perf_reload;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [63:0] sb[$];
  int          modelHead   = 0;
  int          modelTail   = 0;
  int          modelReload = 0;

  instrs_buff #(.DEPTH(DEPTH), .PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .flush      (flush),
    .perf_head  (perf_head),
    .perf_tail  (perf_tail),
    .perf_reload(perf_reload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return (pc * 32'd3) ^ 32'hDEADBEEF;
  endfunction

  // Drives one cycle. Pre-edge checks run on the state left by the previous
  // edge; the scoreboard front is popped when decode takes an entry.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic r,
                               input logic f, input logic rs);
    logic        acc;
    logic        deq;
    logic [63:0] head_entry;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instrOf(pc);
    out_ready = r;
    flush     = f;
    rst       = rs;
    acc = v && (sb.size() < DEPTH) && !f && !rs;
    deq = r && (sb.size() != 0) && !f && !rs;
    if (!rs) begin
      checkOutput("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      checkOutput("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
      if (deq) begin
        head_entry = sb.pop_front();
        checkOutput("out_pc", out_pc, head_entry[63:32]);
        checkOutput("out_instr", out_instr, head_entry[31:0]);
      end
    end
    @(posedge clk);
    if (rs) begin
      sb.delete();
      modelHead   = 0;
      modelTail   = 0;
      modelReload = 0;
    end else if (f) begin
      sb.delete();
      modelHead   = 0;
      modelTail   = 0;
      modelReload = 1;
    end else begin
      modelReload = 0;
      if (acc) begin
        sb.push_back({pc, instrOf(pc)});
        modelTail = (modelTail + 1) % (2 * DEPTH);
      end
      if (deq) modelHead = (modelHead + 1) % (2 * DEPTH);
    end
    #1;
    checkOutput("perf_head", {24'd0, perf_head}, 32'(modelHead % DEPTH));
    checkOutput("perf_tail", {24'd0, perf_tail}, 32'(modelTail % DEPTH));
    checkOutput("perf_reload", {24'd0, perf_reload}, 32'(modelReload));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
    #1;

    // Reset for two cycles, then idle.
    applyStimulus(0, 32'h0, 0, 0, 1);
    applyStimulus(0, 32'h0, 0, 0, 1);
    applyStimulus(0, 32'h0, 0, 0, 0);

    // Fill to full, then offer a fifth entry that must be refused.
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'h100 + 32'(4 * i), 0, 0, 0);
    applyStimulus(1, 32'h110, 0, 0, 0);

    // Drain in order.
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 1, 0, 0);
    applyStimulus(0, 32'h0, 0, 0, 0);

    // Move head to index 3, then hold two entries at indices 3 and 0.
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h200 + 32'(4 * i), 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 1, 0, 0);
    applyStimulus(1, 32'h20C, 0, 0, 0);
    applyStimulus(1, 32'h210, 0, 0, 0);

    // Simultaneous push and pop across the wrap point.
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h214 + 32'(4 * i), 1, 0, 0);

    // Third entry, then flush with both handshakes active.
    applyStimulus(1, 32'h220, 0, 0, 0);
    applyStimulus(1, 32'h224, 1, 1, 0);
    applyStimulus(0, 32'h0, 0, 0, 0);
    applyStimulus(0, 32'h0, 0, 0, 0);

    // Back-to-back flushes keep perf_reload high.
    applyStimulus(1, 32'h300, 0, 0, 0);
    applyStimulus(1, 32'h304, 0, 1, 0);
    applyStimulus(1, 32'h308, 0, 1, 0);
    applyStimulus(0, 32'h0, 0, 0, 0);

    // Reset mid-stream together with flush.
    applyStimulus(1, 32'h400, 0, 0, 0);
    applyStimulus(1, 32'h404, 0, 0, 0);
    applyStimulus(1, 32'h408, 1, 1, 1);
    applyStimulus(0, 32'h0, 0, 0, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * i),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(0, 32'h0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
